timer_digit_editor: RTL and testbench
=====================================

Name: timer_digit_editor

Overview:
- Consumes the one-hot digit-select vector from the timer's digit-select circular shift register and applies user up/down button presses to the selected BCD digit of the MM:SS timer setpoint.
- Holds the four setpoint digits, which the countdown and display logic read.
- Supports single-step per press and hold-to-auto-repeat.

Parameters:
- REPEAT_DELAY, 50000000, cycles a button must be held after the first step before auto-repeat begins (min 2).
- REPEAT_PERIOD, 10000000, cycles between auto-repeat steps (min 2).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous active-high reset.
- i_digit_select  input  4  one-hot digit select: bit0 sec ones, bit1 sec tens, bit2 min ones, bit3 min tens.
- i_edit_en  input  1  editing permitted (timer stopped); when low, no digit changes.
- i_inc  input  1  debounced, synchronised increment button level.
- i_dec  input  1  debounced, synchronised decrement button level.
- o_time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- o_step  output  1  one-cycle pulse, high the cycle after any digit change.
- o_select_error  output  1  registered; high while a step was suppressed because i_digit_select was not one-hot.

Behaviour:
- Reset (synchronous, active-high):
  - o_time_bcd = 16'h0000; o_step = 0; o_select_error = 0.
  - FSM returns to IDLE; counter = 0.
  - Edge registers load the current i_inc/i_dec, so a button held through reset does not step.
- Edge detection: a rise is the input high this cycle with its registered previous value low.
- Step rules, applied to the digit selected at the stepping edge only; no carry or borrow between digits:
  - Ones digits and min tens count 0-9. Increment 9->0; decrement 0->9.
  - Sec tens counts 0-5. Increment 5->0; decrement 0->5.
- Step latency: new value is visible on o_time_bcd immediately after the stepping clock edge. o_step is high for exactly one cycle following that edge.
- Invalid select (zero or multiple bits set) at a would-be step:
  - Digits are unchanged and o_step stays 0.
  - o_select_error is set and remains set until the next successful step or reset.
- FSM:
  - IDLE: a step fires when one of i_inc/i_dec rises, the other is low, and i_edit_en = 1. On that step: latch direction, clear counter, go to DELAY.
    - Both rising in the same cycle: no step, stay IDLE.
  - DELAY: counter increments each cycle. When counter = REPEAT_DELAY-1: step, clear counter, go to REPEAT.
  - REPEAT: counter increments. When counter = REPEAT_PERIOD-1: step, clear counter.
  - Exits from DELAY or REPEAT to IDLE, with counter cleared and no step that cycle, on any of:
    - latched-direction input goes low;
    - opposite input is high;
    - i_edit_en goes low.
  - Re-press after returning to IDLE requires a fresh rise.
- i_digit_select changing during DELAY/REPEAT: the FSM continues, and subsequent steps apply to the newly selected digit.
- Digits never take non-BCD values; sec tens never exceeds 5.
- Counter width: $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: DELAY/REPEAT auto-repeat behaviour as above.
- Undefined: exactly one step per press. The FSM reduces to IDLE/HELD, where HELD waits for both buttons to be released (or i_edit_en low) before returning to IDLE. The counter and repeat parameters are unused.

Test Plan (REPEAT_DELAY=4, REPEAT_PERIOD=2):
- Reset, select 4'b0001, pulse i_inc 1 cycle, 10 times -> o_time_bcd walks 0001..0009 then 0000; o_step pulses 10 times.
- Select 4'b0010, start 16'h0000, pulse i_dec once -> 16'h0050. Pulse i_inc once -> 16'h0000. Other digits unchanged throughout.
- AUTO_REPEAT_EN, select 4'b0100, hold i_inc 12 cycles from 16'h0000:
  - first step on the press edge, second 4 cycles later, then every 2 cycles;
  - result 16'h0500 (5 steps);
  - release -> no further steps.
- Hold i_inc, then raise i_dec 2 cycles later -> one step only, FSM back in IDLE, no repeat. Simultaneous rise of both -> no step.
- Select 4'b0110, pulse i_inc -> digits unchanged, o_select_error = 1, o_step = 0. Then select 4'b1000, pulse i_inc -> min tens +1, o_select_error = 0.
- i_edit_en = 0, pulse i_inc -> no change. Hold i_inc through reset assertion and release -> no step after reset. i_edit_en dropped mid-repeat -> repeat stops that cycle.

Source files
------------

// File: rtl/timer_digit_editor.sv
// Applies up/down button presses to the selected BCD digit of an MM:SS setpoint.
// Define AUTO_REPEAT_EN for hold-to-auto-repeat; otherwise one step per press.
module timer_digit_editor #(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_digit_select,
  input  logic        i_edit_en,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic [15:0] o_time_bcd,
  output logic        o_step,
  output logic        o_select_error
);

  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("timer_digit_editor: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
  end

  logic        incPrev_q, decPrev_q;
  logic        incRise, decRise, pressUp, pressDn;
  logic        wouldStep, stepUp, selValid, stepValid;
  logic [15:0] time_q, time_d;
  logic        step_q;
  logic        err_q, err_d;

  assign incRise = i_inc & ~incPrev_q;
  assign decRise = i_dec & ~decPrev_q;
  // A press only counts when the opposite button is released.
  assign pressUp = incRise & ~i_dec & i_edit_en;
  assign pressDn = decRise & ~i_inc & i_edit_en;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dirUp_q, dirUp_d;
  logic             holdBroken;

  assign holdBroken = ~i_edit_en | (dirUp_q ? (~i_inc | i_dec) : (~i_dec | i_inc));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dirUp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dirUp_q <= dirUp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pressUp || pressDn) state_d = DELAY;
      DELAY:   if (holdBroken) state_d = IDLE;
               else if (cnt_q == DELAY_LAST) state_d = REPEAT;
      REPEAT:  if (holdBroken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wouldStep = 1'b0;
    stepUp    = dirUp_q;
    dirUp_d   = dirUp_q;
    cnt_d     = '0;
    case (state_q)
      IDLE: begin
        stepUp = pressUp;
        if (pressUp || pressDn) begin
          wouldStep = 1'b1;
          dirUp_d   = pressUp;
        end
      end
      DELAY: begin
        if (!holdBroken) begin
          if (cnt_q == DELAY_LAST) wouldStep = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!holdBroken) begin
          if (cnt_q == PERIOD_LAST) wouldStep = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end
`else
  typedef enum logic {IDLE, HELD} state_t;
  state_t state_q, state_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // HELD blocks further steps until both buttons are released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pressUp || pressDn) state_d = HELD;
      HELD:    if ((!i_inc && !i_dec) || !i_edit_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wouldStep = (state_q == IDLE) && (pressUp || pressDn);
    stepUp    = pressUp;
  end
`endif

  function automatic logic [3:0] bumpDigit(input logic [3:0] d, input logic [3:0] top,
                                           input logic up);
    if (up) return (d >= top) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0 || d > top) ? top : d - 4'd1;
  endfunction

  assign selValid  = $onehot(i_digit_select);
  assign stepValid = wouldStep & selValid;

  // Sec tens wraps at 5; every other digit wraps at 9, with no carry between digits.
  always_comb begin
    time_d = time_q;
    for (int i = 0; i < 4; i++) begin
      if (stepValid && i_digit_select[i])
        time_d[4*i +: 4] = bumpDigit(time_q[4*i +: 4], (i == 1) ? 4'd5 : 4'd9, stepUp);
    end
    err_d = err_q;
    if (stepValid)      err_d = 1'b0;
    else if (wouldStep) err_d = 1'b1;
  end

  // Edge registers load the live buttons in reset so a held button cannot step afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      incPrev_q <= i_inc;
      decPrev_q <= i_dec;
      time_q    <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      incPrev_q <= i_inc;
      decPrev_q <= i_dec;
      time_q    <= time_d;
      step_q    <= stepValid;
      err_q     <= err_d;
    end
  end

  assign o_time_bcd     = time_q;
  assign o_step         = step_q;
  assign o_select_error = err_q;

endmodule

// File: tb/tb_timer_digit_editor.sv
// Self-checking bench for timer_digit_editor (REPEAT_DELAY=4, REPEAT_PERIOD=2).
// Covers the AUTO_REPEAT_EN build when that macro is defined, the single-step build otherwise.
module tb_timer_digit_editor;

  localparam int REPEAT_DELAY  = 4;
  localparam int REPEAT_PERIOD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic        en, inc, dec;
  logic [15:0] timeBcd;
  logic        stepO, errO;

  always #5 clk = ~clk;

  timer_digit_editor #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_digit_select (sel),
    .i_edit_en      (en),
    .i_inc          (inc),
    .i_dec          (dec),
    .o_time_bcd     (timeBcd),
    .o_step         (stepO),
    .o_select_error (errO)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic        inc;
    logic        dec;
    logic [15:0] expTime;
    logic        expStep;
    logic        expErr;
    string       tag;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        step;
    logic        err;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic void addVec(input logic [3:0] s, input logic e, input logic i,
                                 input logic d, input logic [15:0] t, input logic st,
                                 input logic er, input string tag);
    vec_t v;
    v.sel = s; v.en = e; v.inc = i; v.dec = d;
    v.expTime = t; v.expStep = st; v.expErr = er; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s/%s: actual %h required %h at %0t", tag, field, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: actual empty required one entry at %0t", $time);
    end else begin
      e = scoreboard.pop_front();
      checkField(e.tag, "time", timeBcd, e.bcd);
      checkField(e.tag, "step", {15'd0, stepO}, {15'd0, e.step});
      checkField(e.tag, "selErr", {15'd0, errO}, {15'd0, e.err});
    end
  endtask

  // Drive at the falling edge, expect the result of the next rising edge.
  task automatic applyStimulus(input logic [3:0] s, input logic e, input logic i,
                               input logic d, input logic [15:0] t, input logic st,
                               input logic er, input string tag);
    exp_t x;
    sel = s; en = e; inc = i; dec = d;
    x.bcd = t; x.step = st; x.err = er; x.tag = tag;
    scoreboard.push_back(x);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset(input logic holdInc, input string tag);
    exp_t x;
    rst = 1'b1; inc = holdInc; dec = 1'b0;
    x.bcd = 16'h0000; x.step = 1'b0; x.err = 1'b0; x.tag = tag;
    scoreboard.push_back(x);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] digitExp;
    logic       hit;
    rst = 1'b1; sel = 4'b0000; en = 1'b0; inc = 1'b0; dec = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      addVec(4'b0001, 1'b1, 1'b1, 1'b0, 16'(k % 10), 1'b1, 1'b0, "secOnesUp");
      addVec(4'b0001, 1'b1, 1'b0, 1'b0, 16'(k % 10), 1'b0, 1'b0, "secOnesRel");
    end
    addVec(4'b0010, 1'b1, 1'b0, 1'b1, 16'h0050, 1'b1, 1'b0, "secTensDecWrap");
    addVec(4'b0010, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, "secTensRel");
    addVec(4'b0010, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "secTensIncWrap");
    addVec(4'b0010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "secTensRel");
    addVec(4'b0100, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, "minOnesUp");
    addVec(4'b0100, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "minOnesRel");
    addVec(4'b1000, 1'b1, 1'b0, 1'b1, 16'h9100, 1'b1, 1'b0, "minTensDecWrap");
    addVec(4'b1000, 1'b1, 1'b0, 1'b0, 16'h9100, 1'b0, 1'b0, "minTensRel");
    addVec(4'b1000, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, "minTensIncWrap");
    addVec(4'b1000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "minTensRel");
    addVec(4'b0001, 1'b1, 1'b0, 1'b1, 16'h0109, 1'b1, 1'b0, "secOnesDecWrap");
    addVec(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0109, 1'b0, 1'b0, "secOnesRel");
    addVec(4'b0001, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, "secOnesIncWrap");
    addVec(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "secOnesRel");
    addVec(4'b0110, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, "twoHotSelect");
    addVec(4'b0110, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "errSticky");
    addVec(4'b0000, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, "zeroSelect");
    addVec(4'b0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "errSticky");
    addVec(4'b1000, 1'b1, 1'b1, 1'b0, 16'h1100, 1'b1, 1'b0, "errClearedByStep");
    addVec(4'b1000, 1'b1, 1'b0, 1'b0, 16'h1100, 1'b0, 1'b0, "minTensRel");
    addVec(4'b1000, 1'b0, 1'b1, 1'b0, 16'h1100, 1'b0, 1'b0, "editDisabled");
    addVec(4'b1000, 1'b0, 1'b0, 1'b0, 16'h1100, 1'b0, 1'b0, "editDisabledRel");
    addVec(4'b1000, 1'b1, 1'b0, 1'b0, 16'h1100, 1'b0, 1'b0, "editReenabled");
    addVec(4'b0001, 1'b1, 1'b1, 1'b1, 16'h1100, 1'b0, 1'b0, "bothRise");
    addVec(4'b0001, 1'b1, 1'b0, 1'b0, 16'h1100, 1'b0, 1'b0, "bothRel");

    @(negedge clk);
    doReset(1'b0, "reset");
    foreach (vecs[n])
      applyStimulus(vecs[n].sel, vecs[n].en, vecs[n].inc, vecs[n].dec,
                    vecs[n].expTime, vecs[n].expStep, vecs[n].expErr, vecs[n].tag);

    // A flagged select error and a button held across reset must both be cleared/ignored.
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 16'h1100, 1'b0, 1'b1, "errBeforeReset");
    doReset(1'b1, "resetHeldInc");
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "heldThroughReset");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "heldRel");

`ifdef AUTO_REPEAT_EN
    digitExp = 4'd0;
    for (int k = 0; k < 12; k++) begin
      hit = (k == 0) || (k >= REPEAT_DELAY && ((k - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
      if (hit) digitExp++;
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, {4'h0, digitExp, 8'h00}, hit, 1'b0, "autoHold");
    end
    for (int k = 0; k < 3; k++)
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 16'h0500, 1'b0, 1'b0, "autoRelease");

    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 16'h0600, 1'b1, 1'b0, "incThenDecPress");
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 16'h0600, 1'b0, 1'b0, "incThenDecHold");
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1, 16'h0600, 1'b0, 1'b0, "oppositeAborts");
    for (int k = 0; k < 3; k++)
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 16'h0600, 1'b0, 1'b0, "noRepressWithoutRise");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 16'h0600, 1'b0, 1'b0, "incThenDecRel");

    digitExp = 4'd0;
    for (int k = 0; k < 8; k++) begin
      hit = (k == 0) || (k >= REPEAT_DELAY && ((k - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
      if (hit) digitExp++;
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, {12'h060, digitExp}, hit, 1'b0, "repeatBeforeDrop");
    end
    for (int k = 0; k < 4; k++)
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 16'h0603, 1'b0, 1'b0, "editDroppedMidRepeat");
    for (int k = 0; k < 2; k++)
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 16'h0603, 1'b0, 1'b0, "editBackNoRise");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0603, 1'b0, 1'b0, "dropRel");
`else
    for (int k = 0; k < 8; k++)
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 16'h0100, k == 0, 1'b0, "singleStepHold");
    for (int k = 0; k < 2; k++)
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, "decRiseWhileHeld");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, "decStillHeld");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "bothReleased");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "freshDecPress");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "freshDecRel");
    digitExp = 4'd0;
    hit = 1'b0;
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, "heldPress");
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "editDroppedInHeld");
    for (int k = 0; k < 2; k++)
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "editBackNoRise");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, "heldRel");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
